// File: rtl/alu_seq.sv
// Registered multi-function ALU with NZCV flag register and Start/Ready/Done handshake.
// Single-cycle ops complete on the accepting edge; MUL runs an iterative shift-add over WIDTH edges.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic             S,
    input  logic [WIDTH-1:0] Src_A,
    input  logic [WIDTH-1:0] Src_B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags
);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORR = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSB = 4'h7;
    localparam logic [3:0] OP_LSL = 4'h8;
    localparam logic [3:0] OP_LSR = 4'h9;
    localparam logic [3:0] OP_ASR = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           state_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic             s_q;

    logic [WIDTH-1:0]   op_x;
    logic [WIDTH-1:0]   op_y;
    logic               op_cin;
    logic [WIDTH:0]     sum;
    logic               arith_v;
    logic [SHW-1:0]     amt;
    logic [WIDTH:0]     lsl_ext;
    logic [WIDTH:0]     lsr_ext;
    logic [WIDTH:0]     asr_ext;
    logic [2*WIDTH-1:0] ror_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_wr;
    logic [3:0]         alu_flags;
    logic [WIDTH-1:0]   mul_add;
    logic [3:0]         mul_flags;

    // Operand steering for the shared adder; carry-in comes from the flag register at accept time.
    always_comb begin
        op_x   = Src_A;
        op_y   = Src_B;
        op_cin = 1'b0;
        case (ALUControl)
            OP_SUB: begin
                op_y   = ~Src_B;
                op_cin = 1'b1;
            end
            OP_ADC: op_cin = flags_q[1];
            OP_SBC: begin
                op_y   = ~Src_B;
                op_cin = flags_q[1];
            end
            OP_RSB: begin
                op_x   = Src_B;
                op_y   = ~Src_A;
                op_cin = 1'b1;
            end
            default: ;
        endcase
        sum     = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, op_cin};
        arith_v = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (sum[WIDTH-1] != op_x[WIDTH-1]);
    end

    // Shifters carry one extra bit so the last bit shifted out lands at a fixed position.
    always_comb begin
        amt     = Src_B[SHW-1:0];
        lsl_ext = {1'b0, Src_A} << amt;
        lsr_ext = {Src_A, 1'b0} >> amt;
        asr_ext = $signed({Src_A, 1'b0}) >>> amt;
        ror_ext = {Src_A, Src_A} >> amt;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = flags_q[1];
        alu_v   = flags_q[0];
        alu_wr  = 1'b1;
        case (ALUControl)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_RSB: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = arith_v;
            end
            OP_AND: alu_res = Src_A & Src_B;
            OP_ORR: alu_res = Src_A | Src_B;
            OP_EOR: alu_res = Src_A ^ Src_B;
            OP_LSL: begin
                alu_res = lsl_ext[WIDTH-1:0];
                if (amt != '0) alu_c = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                alu_res = lsr_ext[WIDTH:1];
                if (amt != '0) alu_c = lsr_ext[0];
            end
            OP_ASR: begin
                alu_res = asr_ext[WIDTH:1];
                if (amt != '0) alu_c = asr_ext[0];
            end
            OP_ROR: begin
                alu_res = ror_ext[WIDTH-1:0];
                if (amt != '0) alu_c = ror_ext[WIDTH-1];
            end
            default: alu_wr = 1'b0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    always_comb begin
        mul_add   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_flags = {mul_add[WIDTH-1], (mul_add == '0), flags_q[1:0]};
    end

    // state  | meaning
    // IDLE   | Ready high; non-MUL ops complete on the accepting edge
    // MUL    | one shift-add iteration per edge, WIDTH edges total
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            s_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        if (ALUControl == OP_MUL) begin
                            mcand_q  <= Src_A;
                            mplier_q <= Src_B;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            s_q      <= S;
                            ready_q  <= 1'b0;
                            state_q  <= ST_MUL;
                        end else begin
                            result_q <= alu_res;
                            if (S && alu_wr) flags_q <= alu_flags;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_q    <= mul_add;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        result_q <= mul_add;
                        if (s_q) flags_q <= mul_flags;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Ready     = ready_q;
    assign Done      = done_q;
    assign ALUResult = result_q;
    assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Table-driven bench for alu_seq with a result/flag scoreboard popped on each Done pulse.
module tb_alu_seq;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         Start = 1'b0;
    logic [3:0]   ALUControl = '0;
    logic         S = 1'b0;
    logic [W-1:0] Src_A = '0;
    logic [W-1:0] Src_B = '0;
    logic         Ready;
    logic         Done;
    logic [W-1:0] ALUResult;
    logic [3:0]   ALUFlags;

    alu_seq #(.WIDTH(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .ALUControl(ALUControl), .S(S),
        .Src_A(Src_A), .Src_B(Src_B), .Ready(Ready), .Done(Done),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int n_done = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
        int           id;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    typedef struct {
        logic [3:0]   op;
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [3:0]   f;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (RESETn && Done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done result=%h flags=%b", ALUResult, ALUFlags);
            end else begin
                e = sb.pop_front();
                chk($sformatf("result_op%0d", e.id), 64'(ALUResult), 64'(e.r));
                chk($sformatf("flags_op%0d", e.id), 64'(ALUFlags), 64'(e.f));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic [3:0] f,
                        input int id);
        @(negedge CLK);
        ALUControl = op;
        S          = s;
        Src_A      = a;
        Src_B      = b;
        Start      = 1'b1;
        sb.push_back('{r, f, id});
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge CLK);
        chk({nm, "_drain_left"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int rdy_low;
        int d0;

        tbl[0]  = '{4'h0, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        tbl[1]  = '{4'h1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        tbl[2]  = '{4'h5, 1'b1, 32'h00000001, 32'h00000002, 32'h00000004, 4'b0000};
        tbl[3]  = '{4'h6, 1'b1, 32'h00000001, 32'h00000002, 32'hFFFFFFFE, 4'b1000};
        tbl[4]  = '{4'hA, 1'b1, 32'h80000010, 32'h00000004, 32'hF8000001, 4'b1000};
        tbl[5]  = '{4'h1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        tbl[6]  = '{4'h9, 1'b1, 32'h00001234, 32'h00000000, 32'h00001234, 4'b0010};
        tbl[7]  = '{4'hB, 1'b1, 32'h00000001, 32'h00000001, 32'h80000000, 4'b1010};
        tbl[8]  = '{4'h4, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0010};
        tbl[9]  = '{4'h2, 1'b1, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 4'b0110};
        tbl[10] = '{4'h3, 1'b0, 32'h80000000, 32'h00000001, 32'h80000001, 4'b0110};
        tbl[11] = '{4'h7, 1'b1, 32'h00000003, 32'h0000000A, 32'h00000007, 4'b0010};
        tbl[12] = '{4'h8, 1'b1, 32'h40000001, 32'h00000001, 32'h80000002, 4'b1000};
        tbl[13] = '{4'h9, 1'b1, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0010};
        tbl[14] = '{4'h0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        tbl[15] = '{4'h1, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        tbl[16] = '{4'hD, 1'b1, 32'h12345678, 32'h11111111, 32'h00000000, 4'b0011};
        tbl[17] = '{4'hA, 1'b1, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b1001};
        tbl[18] = '{4'hB, 1'b1, 32'h12345678, 32'h00000008, 32'h78123456, 4'b0001};
        tbl[19] = '{4'h1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110};
        tbl[20] = '{4'h1, 1'b0, 32'h00000003, 32'h00000007, 32'hFFFFFFFC, 4'b0110};
        tbl[21] = '{4'hE, 1'b1, 32'hDEADBEEF, 32'h00000003, 32'h00000000, 4'b0110};

        repeat (2) @(negedge CLK);
        chk("reset_result", 64'(ALUResult), 64'd0);
        chk("reset_flags", 64'(ALUFlags), 64'd0);
        chk("reset_ready", 64'(Ready), 64'd1);
        chk("reset_done", 64'(Done), 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;

        // back-to-back: one accept per cycle, flags chain from one vector into the next
        for (int i = 0; i < 22; i++)
            send(tbl[i].op, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f, i);
        @(negedge CLK);
        Start = 1'b0;
        drain("table");

        // MUL with a competing Start held during the operation
        send(4'hC, 1'b1, 32'h00010000, 32'h00010001, 32'h00010000, 4'b0010, 100);
        d0 = n_done;
        lat = 0;
        rdy_low = 0;
        @(posedge CLK);
        #2;
        if (Ready === 1'b0) rdy_low++;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK);
            #2;
            if (Done === 1'b1) begin
                lat = i;
                break;
            end
            if (Ready === 1'b0) rdy_low++;
            if (i == 3) begin
                ALUControl = 4'h0;
                Src_A = $urandom;
                Src_B = $urandom;
            end
            if (i == 20) Start = 1'b0;
        end
        Start = 1'b0;
        chk("mul_done_edges", 64'(lat), 64'(W));
        chk("mul_ready_low_cycles", 64'(rdy_low), 64'(W));
        drain("mul");
        repeat (5) @(negedge CLK);
        chk("mul_single_done", 64'(n_done - d0), 64'd1);

        // asynchronous reset in the middle of a MUL
        send(4'hC, 1'b1, 32'h00000003, 32'h00000005, 32'h0000000F, 4'b0000, 200);
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        chk("mid_mul_ready", 64'(Ready), 64'd0);
        #2;
        RESETn = 1'b0;
        #1;
        chk("mid_rst_result", 64'(ALUResult), 64'd0);
        chk("mid_rst_flags", 64'(ALUFlags), 64'd0);
        chk("mid_rst_ready", 64'(Ready), 64'd1);
        chk("mid_rst_done", 64'(Done), 64'd0);
        sb.delete();
        d0 = n_done;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        repeat (40) @(negedge CLK);
        chk("post_rst_no_done", 64'(n_done - d0), 64'd0);

        send(4'h0, 1'b1, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 300);
        @(posedge CLK);
        #2;
        chk("add_after_rst_done", 64'(Done), 64'd1);
        @(negedge CLK);
        Start = 1'b0;
        drain("post_rst");
        @(negedge CLK);
        chk("done_one_cycle", 64'(Done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
